lilme_cmd_seq: RTL and testbench
================================

Name: lilme_cmd_seq

Overview:
- Command sequencer that drives the LilME matrix engine opcode interface on behalf of a host.
- On a single start pulse it performs the full job in order: load address, fetch and load matrix A, fetch and load matrix B, multiply, then read back every result element.
- Sits between a simple word-read memory port and LilME.
- Is the initiator side of the ME_opcode/A_opcode/B_opcode/Data_in protocol that LilME responds to.

Parameters:
- dw, 31, data MSB index (data width dw+1)
- aw, 31, address MSB index (address width aw+1)
- row, 4, matrix rows
- col, 4, matrix columns; N = row*col elements per matrix
- TIMEOUT, 1024, max cycles to wait for Busy to drop after MUL
- RD_LAT, 1, cycles from READ_MUL issue to valid `result`

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle job request; sampled only in IDLE
- base_addr  in  aw+1  job base address, latched on accepted start
- job_busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at job end
- error  out  1  set with done on timeout; cleared on next accepted start
- mem_rd_en  out  1  one-cycle memory read request
- mem_addr  out  aw+1  memory read address
- mem_rd_valid  in  1  read data valid (any latency ≥1)
- mem_rd_data  in  dw+1  read data
- ME_opcode  out  3  engine opcode: 000 IDLE, 001 LOAD_ADDR, 010 LOAD_A, 011 LOAD_B, 101 MUL, 111 READ_MUL
- A_opcode  out  1  qualifies LOAD_A word
- B_opcode  out  1  qualifies LOAD_B word
- Address_out  out  aw+1  engine address
- Data_in  out  dw+1  engine write data
- Busy  in  1  engine busy
- result  in  dw+1  engine result word
- res_valid  out  1  one-cycle result-strobe
- res_index  out  clog2(N)  element index of res_data (0..N-1, row-major)
- res_data  out  dw+1  captured result

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0 (ME_opcode=000, error=0); counters and latched base cleared. A job in flight is abandoned; no done pulse.
- States: IDLE → LD_ADDR → FETCH_A ⇄ PUSH_A → FETCH_B ⇄ PUSH_B → MUL → WAIT → READ → DONE → IDLE.
- IDLE:
  - start=1 latches base_addr, clears error, sets job_busy, and goes to LD_ADDR.
  - start in any other state is ignored.
- LD_ADDR:
  - If Busy=0, drive ME_opcode=001 with Address_out=base for exactly one cycle, then go to FETCH_A with i=0.
  - If Busy=1, hold ME_opcode=000 and wait.
- FETCH_A:
  - Pulse mem_rd_en for one cycle with mem_addr=base+i.
  - Hold until mem_rd_valid, then capture the data and go to PUSH_A.
  - mem_rd_valid outside a pending request is ignored.
- PUSH_A:
  - When Busy=0, drive ME_opcode=010, A_opcode=1, Data_in=word for exactly one cycle.
  - Then, if i==N-1, go to FETCH_B with i=0; otherwise i+1 and back to FETCH_A.
  - If Busy=1, opcode stays 000 and the word is held.
- FETCH_B/PUSH_B: identical to A, with mem_addr=base+N+i, ME_opcode=011, B_opcode=1.
- MUL:
  - When Busy=0, drive ME_opcode=101 for one cycle.
  - Go to WAIT and load the timeout counter.
- WAIT:
  - The first cycle after MUL is ignored (engine Busy-rise slack).
  - Thereafter Busy=0 → READ with i=0.
  - The counter reaching TIMEOUT → DONE with error=1; no reads are issued.
- READ:
  - For each i, drive ME_opcode=111, Address_out=base+i for one cycle.
  - Exactly RD_LAT cycles later, capture `result` into res_data and pulse res_valid with res_index=i.
  - Next issue follows capture (one read outstanding). After i=N-1 capture, go to DONE.
- DONE: one cycle; done=1, job_busy→0 next cycle, return to IDLE.
- All address arithmetic is modulo 2^(aw+1) (wraps silently).
- A_opcode/B_opcode are high only in their push cycle.
- Data_in holds its last value otherwise (not required to be zero).
- Simultaneous start and done: start is ignored (state is not IDLE).

Test Plan:
- Reset mid-PUSH_A (assert reset while ME_opcode=010) → same-cycle async clear: ME_opcode=000, A_opcode=0, job_busy=0; no done after release.
- Nominal job, base=0x100, memory returns 0xA5A5A5A5 for A and 0x5A5A5A5A for B with latency 1, Busy always 0 → sequence:
  - one 001 cycle with Address_out=0x100;
  - 16 LOAD_A words from 0x100..0x10F, then 16 LOAD_B words from 0x110..0x11F;
  - one 101 cycle;
  - 16 res_valid pulses with res_index 0..15;
  - then done=1, error=0.
- Busy backpressure: hold Busy=1 for 5 cycles during PUSH_B word 3 → ME_opcode stays 000 for those cycles; the word is issued once, unchanged, on the first Busy=0 cycle.
- Variable memory latency (3 cycles) and a spurious mem_rd_valid in IDLE → no extra words pushed; total LOAD_A count still 16.
- Timeout: Busy stuck high after MUL → done and error=1 exactly TIMEOUT cycles later; zero 111 opcodes issued; the next start clears error.
- Address wrap: base=0xFFFFFFF8 → A fetch addresses wrap from 0xFFFFFFFF to 0x00000000..0x00000007; B starts at 0x00000008.

Source files
------------

// File: rtl/lilme_cmd_seq.sv
// Host-side command sequencer for the LilME matrix engine: loads the base address,
// streams A and B from memory, issues MUL, then reads every result element back.
module lilme_cmd_seq #(
    parameter int dw      = 31,
    parameter int aw      = 31,
    parameter int row     = 4,
    parameter int col     = 4,
    parameter int TIMEOUT = 1024,
    parameter int RD_LAT  = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [aw:0]                   base_addr,
    output logic                          job_busy,
    output logic                          done,
    output logic                          error,
    output logic                          mem_rd_en,
    output logic [aw:0]                   mem_addr,
    input  logic                          mem_rd_valid,
    input  logic [dw:0]                   mem_rd_data,
    output logic [2:0]                    ME_opcode,
    output logic                          A_opcode,
    output logic                          B_opcode,
    output logic [aw:0]                   Address_out,
    output logic [dw:0]                   Data_in,
    input  logic                          Busy,
    input  logic [dw:0]                   result,
    output logic                          res_valid,
    output logic [$clog2(row*col)-1:0]    res_index,
    output logic [dw:0]                   res_data
);

    localparam int N  = row * col;
    localparam int IW = $clog2(N);
    localparam int AW = aw + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int LW = $clog2(RD_LAT + 1);

    localparam logic [2:0] OP_IDLE     = 3'b000;
    localparam logic [2:0] OP_LOAD_ADR = 3'b001;
    localparam logic [2:0] OP_LOAD_A   = 3'b010;
    localparam logic [2:0] OP_LOAD_B   = 3'b011;
    localparam logic [2:0] OP_MUL      = 3'b101;
    localparam logic [2:0] OP_READ     = 3'b111;

    typedef enum logic [3:0] {
        S_IDLE, S_LD_ADDR, S_FETCH_A, S_PUSH_A, S_FETCH_B, S_PUSH_B,
        S_MUL, S_WAIT, S_READ, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [aw:0]     base_q, base_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [dw:0]     word_q, word_d;
    logic            mem_pend_q, mem_pend_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            rd_pend_q, rd_pend_d;
    logic [LW-1:0]   lat_q, lat_d;
    logic            error_q, error_d;
    logic            res_valid_q, res_valid_d;
    logic [IW-1:0]   res_index_q, res_index_d;
    logic [dw:0]     res_data_q, res_data_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            idx_q       <= '0;
            word_q      <= '0;
            mem_pend_q  <= 1'b0;
            tmo_q       <= '0;
            rd_pend_q   <= 1'b0;
            lat_q       <= '0;
            error_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_index_q <= '0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            mem_pend_q  <= mem_pend_d;
            tmo_q       <= tmo_d;
            rd_pend_q   <= rd_pend_d;
            lat_q       <= lat_d;
            error_q     <= error_d;
            res_valid_q <= res_valid_d;
            res_index_q <= res_index_d;
            res_data_q  <= res_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        idx_d       = idx_q;
        word_d      = word_q;
        mem_pend_d  = mem_pend_q;
        tmo_d       = tmo_q;
        rd_pend_d   = rd_pend_q;
        lat_d       = lat_q;
        error_d     = error_q;
        res_valid_d = 1'b0;
        res_index_d = res_index_q;
        res_data_d  = res_data_q;
        ME_opcode   = OP_IDLE;
        A_opcode    = 1'b0;
        B_opcode    = 1'b0;
        mem_rd_en   = 1'b0;
        done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    error_d = 1'b0;
                    idx_d   = '0;
                    state_d = S_LD_ADDR;
                end
            end
            S_LD_ADDR: begin
                if (!Busy) begin
                    ME_opcode = OP_LOAD_ADR;
                    idx_d     = '0;
                    state_d   = S_FETCH_A;
                end
            end
            S_FETCH_A, S_FETCH_B: begin
                // One request per word; valid is only honoured while a request is pending.
                if (!mem_pend_q) begin
                    mem_rd_en  = 1'b1;
                    mem_pend_d = 1'b1;
                end else if (mem_rd_valid) begin
                    word_d     = mem_rd_data;
                    mem_pend_d = 1'b0;
                    state_d    = (state_q == S_FETCH_A) ? S_PUSH_A : S_PUSH_B;
                end
            end
            S_PUSH_A: begin
                if (!Busy) begin
                    ME_opcode = OP_LOAD_A;
                    A_opcode  = 1'b1;
                    if (idx_q == IW'(N - 1)) begin
                        idx_d   = '0;
                        state_d = S_FETCH_B;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = S_FETCH_A;
                    end
                end
            end
            S_PUSH_B: begin
                if (!Busy) begin
                    ME_opcode = OP_LOAD_B;
                    B_opcode  = 1'b1;
                    if (idx_q == IW'(N - 1)) begin
                        idx_d   = '0;
                        state_d = S_MUL;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = S_FETCH_B;
                    end
                end
            end
            S_MUL: begin
                if (!Busy) begin
                    ME_opcode = OP_MUL;
                    tmo_d     = TW'(1);
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                // tmo_q counts cycles since MUL; cycle 1 is skipped so the engine can raise Busy.
                tmo_d = tmo_q + TW'(1);
                if (tmo_q != TW'(1) && !Busy) begin
                    idx_d   = '0;
                    state_d = S_READ;
                end else if (tmo_q >= TW'(TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_READ: begin
                if (!rd_pend_q) begin
                    ME_opcode = OP_READ;
                    rd_pend_d = 1'b1;
                    lat_d     = LW'(1);
                end else if (lat_q == LW'(RD_LAT)) begin
                    res_valid_d = 1'b1;
                    res_index_d = idx_q;
                    res_data_d  = result;
                    rd_pend_d   = 1'b0;
                    if (idx_q == IW'(N - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign job_busy    = (state_q != S_IDLE);
    assign error       = error_q;
    assign Address_out = base_q + AW'(idx_q);
    assign mem_addr    = base_q + AW'(idx_q) + ((state_q == S_FETCH_B) ? AW'(N) : '0);
    assign Data_in     = word_q;
    assign res_valid   = res_valid_q;
    assign res_index   = res_index_q;
    assign res_data    = res_data_q;

endmodule

// File: tb/tb_lilme_cmd_seq.sv
// Directed bench for lilme_cmd_seq: memory and engine models driven on the falling edge,
// all DUT outputs sampled 1 time unit later, well before the next rising edge.
module tb_lilme_cmd_seq;

    localparam int N       = 16;
    localparam int TIMEOUT = 1024;

    logic        clk = 1'b0;
    logic        reset, start, Busy, mem_rd_valid;
    logic [31:0] base_addr, mem_rd_data, result;
    logic        job_busy, done, error, mem_rd_en, A_opcode, B_opcode, res_valid;
    logic [31:0] mem_addr, Address_out, Data_in, res_data;
    logic [2:0]  ME_opcode;
    logic [3:0]  res_index;

    always #5 clk = ~clk;

    lilme_cmd_seq #(
        .dw(31), .aw(31), .row(4), .col(4), .TIMEOUT(TIMEOUT), .RD_LAT(1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .job_busy(job_busy), .done(done), .error(error),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .ME_opcode(ME_opcode), .A_opcode(A_opcode), .B_opcode(B_opcode),
        .Address_out(Address_out), .Data_in(Data_in), .Busy(Busy), .result(result),
        .res_valid(res_valid), .res_index(res_index), .res_data(res_data)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int mode, input logic [31:0] addr, input bit is_b);
        if (mode == 0) return is_b ? 32'h5A5A_5A5A : 32'hA5A5_A5A5;
        return addr ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] res_word(input logic [31:0] addr);
        return {16'hC0DE, addr[15:0]};
    endfunction

    // Monitor log
    int          cyc = 0;
    int          n_ld, n_mul, n_rd, n_done, qual_bad, busy_bad, bp_hold;
    int          mul_cyc, done_cyc, rel_cyc, push3_cyc;
    logic [31:0] ld_addr, eng_addr;
    logic [31:0] a_q[$], b_q[$], req_q[$], rd_q[$];
    int          ri_q[$];
    bit          done_err, err_at_start, jb_after_done, prev_busy, prev_done, prev_jb;
    bit          req_new, eng_new, mul_new, bp_trig;

    // Driver state
    int          mem_lat, dmode, m_left, bp_left;
    bit          m_pend, m_isb, bp_armed, to_mode, spur;
    logic [31:0] m_addr, bp_addr;

    task automatic clear_log();
        n_ld = 0; n_mul = 0; n_rd = 0; n_done = 0; qual_bad = 0; busy_bad = 0; bp_hold = 0;
        mul_cyc = 0; done_cyc = 0; rel_cyc = -1; push3_cyc = -2;
        ld_addr = '0; eng_addr = '0;
        a_q.delete(); b_q.delete(); req_q.delete(); rd_q.delete(); ri_q.delete();
        done_err = 1'b0; err_at_start = 1'b1; jb_after_done = 1'b1;
        prev_busy = 1'b0; prev_done = 1'b0; prev_jb = 1'b0;
        req_new = 1'b0; eng_new = 1'b0; mul_new = 1'b0; bp_trig = 1'b0;
        m_left = 0; bp_left = 0; m_pend = 1'b0; m_isb = 1'b0; m_addr = '0;
    endtask

    task automatic tick();
        @(negedge clk);
        mem_rd_valid = 1'b0;
        result = 32'hBAD0_0000 ^ 32'(cyc);
        if (req_new) begin
            req_new = 1'b0;
            m_pend  = 1'b1;
            m_left  = mem_lat;
            m_addr  = req_q[$];
            m_isb   = (req_q.size() > N);
        end
        if (m_pend) begin
            m_left--;
            if (m_left == 0) begin
                m_pend       = 1'b0;
                mem_rd_valid = 1'b1;
                mem_rd_data  = exp_word(dmode, m_addr, m_isb);
            end
        end
        if (spur) begin
            spur         = 1'b0;
            mem_rd_valid = 1'b1;
            mem_rd_data  = 32'hDEAD_BEEF;
        end
        if (eng_new) begin
            eng_new = 1'b0;
            result  = res_word(eng_addr);
        end
        if (bp_left > 0) begin
            bp_left--;
            Busy = (bp_left != 0);
        end
        if (bp_trig) begin
            bp_trig = 1'b0;
            Busy    = 1'b1;
            bp_left = 6;
        end
        if (mul_new) begin
            mul_new = 1'b0;
            Busy    = 1'b1;
        end
        #1;
        cyc++;
        if (ME_opcode == 3'b001) begin n_ld++; ld_addr = Address_out; end
        if (ME_opcode == 3'b010) a_q.push_back(Data_in);
        if (ME_opcode == 3'b011) begin
            if (b_q.size() == 3) push3_cyc = cyc;
            b_q.push_back(Data_in);
        end
        if ((A_opcode != (ME_opcode == 3'b010)) || (B_opcode != (ME_opcode == 3'b011))) qual_bad++;
        if (ME_opcode == 3'b101) begin n_mul++; mul_cyc = cyc; if (to_mode) mul_new = 1'b1; end
        if (ME_opcode == 3'b111) begin n_rd++; eng_new = 1'b1; eng_addr = Address_out; end
        if (mem_rd_en) begin
            req_q.push_back(mem_addr);
            req_new = 1'b1;
            if (bp_armed && mem_addr == bp_addr) bp_trig = 1'b1;
        end
        if (Busy && ME_opcode != 3'b000) busy_bad++;
        if (bp_armed && Busy && ME_opcode == 3'b000) bp_hold++;
        if (prev_busy && !Busy) rel_cyc = cyc;
        prev_busy = Busy;
        if (res_valid) begin ri_q.push_back(int'(res_index)); rd_q.push_back(res_data); end
        if (prev_done) jb_after_done = job_busy;
        prev_done = done;
        if (done) begin n_done++; done_cyc = cyc; done_err = error; end
        if (job_busy && !prev_jb) err_at_start = error;
        prev_jb = job_busy;
    endtask

    task automatic run_job(input logic [31:0] base);
        base_addr = base;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3000 && n_done == 0; k++) tick();
        check_eq("job_done", 64'(n_done != 0), 64'(1));
        repeat (3) tick();
    endtask

    task automatic verify_job(input logic [31:0] base, input bit timed_out);
        int bad;
        check_eq("ld_count", 64'(n_ld), 64'(1));
        check_eq("ld_addr", 64'(ld_addr), 64'(base));
        check_eq("a_count", 64'(a_q.size()), 64'(N));
        check_eq("b_count", 64'(b_q.size()), 64'(N));
        check_eq("req_count", 64'(req_q.size()), 64'(2 * N));
        bad = 0;
        for (int k = 0; k < 2 * N; k++)
            if (k >= req_q.size() || req_q[k] !== base + 32'(k)) bad++;
        check_eq("req_addr_bad", 64'(bad), 64'(0));
        bad = 0;
        for (int k = 0; k < N; k++) begin
            if (k >= a_q.size() || a_q[k] !== exp_word(dmode, base + 32'(k), 1'b0)) bad++;
            if (k >= b_q.size() || b_q[k] !== exp_word(dmode, base + 32'(N + k), 1'b1)) bad++;
        end
        check_eq("push_data_bad", 64'(bad), 64'(0));
        check_eq("mul_count", 64'(n_mul), 64'(1));
        check_eq("qual_bad", 64'(qual_bad), 64'(0));
        check_eq("issue_while_busy", 64'(busy_bad), 64'(0));
        check_eq("done_count", 64'(n_done), 64'(1));
        check_eq("busy_after_done", 64'(jb_after_done), 64'(0));
        check_eq("error_at_start", 64'(err_at_start), 64'(0));
        if (timed_out) begin
            check_eq("to_read_count", 64'(n_rd), 64'(0));
            check_eq("to_res_count", 64'(ri_q.size()), 64'(0));
            check_eq("to_error", 64'(done_err), 64'(1));
            check_eq("to_latency", 64'(done_cyc - mul_cyc), 64'(TIMEOUT));
        end else begin
            check_eq("read_count", 64'(n_rd), 64'(N));
            check_eq("res_count", 64'(ri_q.size()), 64'(N));
            bad = 0;
            for (int k = 0; k < N; k++)
                if (k >= ri_q.size() || ri_q[k] != k || rd_q[k] !== res_word(base + 32'(k))) bad++;
            check_eq("res_bad", 64'(bad), 64'(0));
            check_eq("done_error", 64'(done_err), 64'(0));
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; Busy = 1'b0;
        mem_rd_valid = 1'b0; mem_rd_data = '0; result = '0;
        mem_lat = 1; dmode = 0; bp_armed = 1'b0; bp_addr = '0; to_mode = 1'b0; spur = 1'b0;
        clear_log();
        tick(); tick();
        check_eq("rst_opcode", 64'(ME_opcode), 64'(0));
        check_eq("rst_job_busy", 64'(job_busy), 64'(0));
        check_eq("rst_done", 64'(done), 64'(0));
        check_eq("rst_error", 64'(error), 64'(0));
        check_eq("rst_rd_en", 64'(mem_rd_en), 64'(0));
        check_eq("rst_res_valid", 64'(res_valid), 64'(0));
        check_eq("rst_addr_out", 64'(Address_out), 64'(0));
        check_eq("rst_mem_addr", 64'(mem_addr), 64'(0));
        check_eq("rst_ab_op", 64'({A_opcode, B_opcode}), 64'(0));
        reset = 1'b0;
        tick();

        // Reset while a LOAD_A word is on the bus
        clear_log();
        base_addr = 32'h40;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 200 && a_q.size() < 3; k++) tick();
        check_eq("mid_push_opcode", 64'(ME_opcode), 64'(3'b010));
        reset = 1'b1;
        #1;
        check_eq("arst_opcode", 64'(ME_opcode), 64'(0));
        check_eq("arst_a_opcode", 64'(A_opcode), 64'(0));
        check_eq("arst_job_busy", 64'(job_busy), 64'(0));
        tick(); tick();
        reset = 1'b0;
        clear_log();
        repeat (60) tick();
        check_eq("arst_no_done", 64'(n_done), 64'(0));
        check_eq("arst_idle", 64'(n_ld + a_q.size() + req_q.size()), 64'(0));

        // Nominal job
        clear_log();
        run_job(32'h100);
        verify_job(32'h100, 1'b0);

        // Busy backpressure on B word 3
        clear_log();
        dmode = 1;
        bp_armed = 1'b1;
        bp_addr = 32'h200 + 32'(N) + 32'd3;
        run_job(32'h200);
        verify_job(32'h200, 1'b0);
        check_eq("bp_hold_cycles", 64'(bp_hold), 64'(6));
        check_eq("bp_push_cycle", 64'(push3_cyc), 64'(rel_cyc));
        check_eq("bp_word3", 64'(b_q[3]), 64'(exp_word(1, 32'h213, 1'b1)));
        bp_armed = 1'b0;

        // 3-cycle memory with a stray valid while idle
        clear_log();
        mem_lat = 3;
        spur = 1'b1;
        tick(); tick();
        run_job(32'h300);
        verify_job(32'h300, 1'b0);
        mem_lat = 1;

        // Busy stuck after MUL, then a clean job clears error
        clear_log();
        to_mode = 1'b1;
        run_job(32'h400);
        verify_job(32'h400, 1'b1);
        to_mode = 1'b0;
        Busy = 1'b0;
        tick(); tick();
        check_eq("error_sticky", 64'(error), 64'(1));
        clear_log();
        run_job(32'h500);
        verify_job(32'h500, 1'b0);

        // Address wrap
        clear_log();
        run_job(32'hFFFF_FFF8);
        verify_job(32'hFFFF_FFF8, 1'b0);
        check_eq("wrap_a7", 64'(req_q[7]), 64'(32'hFFFF_FFFF));
        check_eq("wrap_a8", 64'(req_q[8]), 64'(32'h0000_0000));
        check_eq("wrap_b0", 64'(req_q[16]), 64'(32'h0000_0008));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
